// File: rtl/linebuffer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : linebuffer_sequencer
//  Purpose  : Fetches image lines into the linebuffer in K-pixel chunks, then
//             walks its read port over every output pixel (SAME/VALID).
//  Revision : 1.0
// ============================================================================
module linebuffer_sequencer #(
   parameter int K                 = 3,
   parameter int IMAGEWIDTH        = 32,
   parameter int IMAGEHEIGHT       = 32,
   parameter int COLADDRESSWIDTH   = $clog2(IMAGEWIDTH),
   parameter int ROWADDRESSWIDTH   = $clog2(IMAGEHEIGHT),
   parameter int TBROWADDRESSWIDTH = $clog2(K)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         start_i,
   input  logic                         padding_same_i,
   input  logic [COLADDRESSWIDTH:0]     layer_imagewidth_i,
   input  logic [ROWADDRESSWIDTH:0]     layer_imageheight_i,
   output logic                         mem_req_o,
   input  logic                         mem_gnt_i,
   output logic [ROWADDRESSWIDTH-1:0]   mem_row_o,
   output logic [COLADDRESSWIDTH-1:0]   mem_col_o,
   output logic                         lb_flush_o,
   output logic                         lb_write_enable_o,
   output logic [COLADDRESSWIDTH-1:0]   lb_write_col_o,
   output logic                         lb_wrap_around_save_enable_o,
   output logic                         lb_read_enable_o,
   output logic [COLADDRESSWIDTH-1:0]   lb_read_col_o,
   output logic [TBROWADDRESSWIDTH-1:0] lb_read_row_o,
   output logic                         win_valid_o,
   input  logic                         win_ready_i,
   output logic [ROWADDRESSWIDTH-1:0]   win_row_o,
   output logic [COLADDRESSWIDTH-1:0]   win_col_o,
   output logic                         busy_o,
   output logic                         done_o
);

   // Internal arithmetic is two bits wider than the address fields so that
   // "column + K" and "row + P + 1" never wrap.
   localparam int XW = COLADDRESSWIDTH + 2;
   localparam int YW = ROWADDRESSWIDTH + 2;
   localparam int P  = (K - 1) / 2;

   localparam logic [XW-1:0] c_KX  = XW'(K);
   localparam logic [XW-1:0] c_PX  = XW'(P);
   localparam logic [XW-1:0] c_1X  = XW'(1);
   localparam logic [YW-1:0] c_KY  = YW'(K);
   localparam logic [YW-1:0] c_PY  = YW'(P);
   localparam logic [YW-1:0] c_P1Y = YW'(P + 1);
   localparam logic [YW-1:0] c_1Y  = YW'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FLUSH  = 3'd1,
      S_LOAD   = 3'd2,
      S_SETTLE = 3'd3,
      S_EMIT   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t          r_state, w_state_n;
   logic            r_same,   w_same_n;
   logic [XW-1:0]   r_w,      w_w_n;
   logic [YW-1:0]   r_h,      w_h_n;
   logic [XW-1:0]   r_fcol,   w_fcol_n;
   logic [YW-1:0]   r_loaded, w_loaded_n;
   logic [YW-1:0]   r_y,      w_y_n;
   logic [XW-1:0]   r_x,      w_x_n;

   logic [XW-1:0]   w_x_first, w_x_last;
   logic [YW-1:0]   w_y_first, w_y_last;
   logic [YW-1:0]   w_lreq, w_lreq_next;
   logic            w_degenerate;

   // Lines that must be resident before output row y can be emitted.
   function automatic logic [YW-1:0] f_lreq(input logic [YW-1:0] y,
                                            input logic [YW-1:0] h);
      logic [YW-1:0] t;
      t = y + c_P1Y;
      return (t < h) ? t : h;
   endfunction

   always_comb begin
      w_x_first    = r_same ? '0 : c_PX;
      w_x_last     = r_same ? (r_w - c_1X) : (r_w - c_1X - c_PX);
      w_y_first    = r_same ? '0 : c_PY;
      w_y_last     = r_same ? (r_h - c_1Y) : (r_h - c_1Y - c_PY);
      w_degenerate = r_same ? ((r_w == '0) || (r_h == '0))
                            : ((r_w < c_KX) || (r_h < c_KY));
      w_lreq       = f_lreq(r_y, r_h);
      w_lreq_next  = f_lreq(r_y + c_1Y, r_h);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_n;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_same   <= 1'b0;
         r_w      <= '0;
         r_h      <= '0;
         r_fcol   <= '0;
         r_loaded <= '0;
         r_y      <= '0;
         r_x      <= '0;
      end else begin
         r_same   <= w_same_n;
         r_w      <= w_w_n;
         r_h      <= w_h_n;
         r_fcol   <= w_fcol_n;
         r_loaded <= w_loaded_n;
         r_y      <= w_y_n;
         r_x      <= w_x_n;
      end
   end

   always_comb begin
      w_state_n  = r_state;
      w_same_n   = r_same;
      w_w_n      = r_w;
      w_h_n      = r_h;
      w_fcol_n   = r_fcol;
      w_loaded_n = r_loaded;
      w_y_n      = r_y;
      w_x_n      = r_x;

      mem_req_o                    = 1'b0;
      mem_row_o                    = '0;
      mem_col_o                    = '0;
      lb_flush_o                   = 1'b0;
      lb_wrap_around_save_enable_o = 1'b0;
      win_valid_o                  = 1'b0;
      win_row_o                    = '0;
      win_col_o                    = '0;
      lb_read_col_o                = '0;
      lb_read_row_o                = '0;
      done_o                       = 1'b0;
      busy_o                       = (r_state != S_IDLE);

      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_n  = S_FLUSH;
               w_same_n   = padding_same_i;
               w_w_n      = {1'b0, layer_imagewidth_i};
               w_h_n      = {1'b0, layer_imageheight_i};
               w_fcol_n   = '0;
               w_loaded_n = '0;
               w_y_n      = '0;
               w_x_n      = '0;
            end
         end
         S_FLUSH: begin
            lb_flush_o = 1'b1;
            if (w_degenerate) begin
               w_state_n = S_DONE;
            end else begin
               w_y_n     = w_y_first;
               w_x_n     = w_x_first;
               w_state_n = S_LOAD;
            end
         end
         S_LOAD: begin
            mem_req_o = 1'b1;
            mem_row_o = ROWADDRESSWIDTH'(r_loaded);
            mem_col_o = COLADDRESSWIDTH'(r_fcol);
            if (mem_gnt_i) begin
               if (r_fcol + c_KX >= r_w) begin
                  w_fcol_n   = '0;
                  w_loaded_n = r_loaded + c_1Y;
                  w_state_n  = S_SETTLE;
               end else begin
                  w_fcol_n = r_fcol + c_KX;
               end
            end
         end
         S_SETTLE: begin
            w_state_n = (r_loaded < w_lreq) ? S_LOAD : S_EMIT;
         end
         S_EMIT: begin
            win_valid_o   = 1'b1;
            win_row_o     = ROWADDRESSWIDTH'(r_y);
            win_col_o     = COLADDRESSWIDTH'(r_x);
            lb_read_col_o = COLADDRESSWIDTH'(r_x);
            lb_read_row_o = TBROWADDRESSWIDTH'(c_KY - w_lreq + r_y);
            if (win_ready_i) begin
               if (r_x == w_x_last) begin
                  if (r_y == w_y_last) begin
                     w_state_n = S_DONE;
                  end else begin
                     w_y_n     = r_y + c_1Y;
                     w_x_n     = w_x_first;
                     w_state_n = (r_loaded < w_lreq_next) ? S_LOAD : S_EMIT;
                  end
               end else begin
                  w_x_n = r_x + c_1X;
               end
            end
         end
         S_DONE: begin
            done_o    = 1'b1;
            w_state_n = S_IDLE;
         end
         default: begin
            w_state_n = S_IDLE;
         end
      endcase

      lb_write_enable_o = mem_req_o & mem_gnt_i;
      lb_write_col_o    = mem_col_o;
      lb_read_enable_o  = win_valid_o;
   end

endmodule
`default_nettype wire
